result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader.sv | 115 +++++++++++
 tb/tb_result_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// Snapshots an N x N mesh of W-bit cells on START and streams them out row-major over a valid/ready port.
// Optional parity output PAR is enabled with the macro RESULT_READER_PARITY_EN.
module result_reader #(
  parameter int N = 3,
  parameter int W = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            START,
  input  logic                            ABORT,
  input  logic [N*N*W-1:0]                R_IN,
  input  logic                            READY,
  output logic                            VALID,
  output logic [W-1:0]                    DOUT,
  output logic [((N > 2) ? $clog2(N) : 1)-1:0] ROW,
  output logic [((N > 2) ? $clog2(N) : 1)-1:0] COL,
  output logic                            LAST,
  output logic                            BUSY,
  output logic                            DONE
`ifdef RESULT_READER_PARITY_EN
  ,
  output logic                            PAR
`endif
);

  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(CELLS - 1);
  localparam logic [RW-1:0] COL_MAX = RW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CELLS*W-1:0] r_snap;
  logic [IW-1:0]      r_idx;
  logic [RW-1:0]      r_row;
  logic [RW-1:0]      r_col;
  logic [W-1:0]       w_cells [CELLS];
  logic               w_capture;
  logic               w_at_last;
  logic               w_advance;

  // Handshake: a word transfers at a rising edge where VALID=1 and READY=1;
  // VALID never drops while waiting for READY, and DOUT/ROW/COL/LAST hold.
  assign w_capture = (r_state == S_IDLE) && START;
  assign w_at_last = (r_idx == IDX_MAX);
  assign w_advance = (r_state == S_SEND) && READY && !ABORT && !w_at_last;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (START) w_next = S_SEND;
      S_SEND: begin
        if (ABORT)                  w_next = S_IDLE;
        else if (READY && w_at_last) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_snap <= '0;
      r_idx  <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_capture) begin
      r_snap <= R_IN;
      r_idx  <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_advance) begin
      r_idx <= r_idx + IW'(1);
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + RW'(1);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < CELLS; g++) begin : g_cells
      assign w_cells[g] = r_snap[g*W +: W];
    end
  endgenerate

  // Outputs decode only from registered state and the snapshot, never from R_IN.
  assign VALID = (r_state == S_SEND);
  assign DOUT  = w_cells[r_idx];
  assign ROW   = r_row;
  assign COL   = r_col;
  assign LAST  = VALID && w_at_last;
  assign BUSY  = (r_state != S_IDLE);
  assign DONE  = (r_state == S_FIN);

`ifdef RESULT_READER_PARITY_EN
  assign PAR = VALID & (^DOUT);
`endif

endmodule

// File: tb/tb_result_reader.sv
// Table-driven bench for result_reader (N=3, W=4) plus hand-written reset sequences.
// Define RESULT_READER_PARITY_EN for both files to exercise PAR.
module tb_result_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ABORT;
  logic [35:0] R_IN;
  logic        READY;
  logic        VALID;
  logic [3:0]  DOUT;
  logic [1:0]  ROW;
  logic [1:0]  COL;
  logic        LAST;
  logic        BUSY;
  logic        DONE;
`ifdef RESULT_READER_PARITY_EN
  logic        PAR;
`endif

  result_reader #(.N(3), .W(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .ABORT (ABORT),
    .R_IN  (R_IN),
    .READY (READY),
    .VALID (VALID),
    .DOUT  (DOUT),
    .ROW   (ROW),
    .COL   (COL),
    .LAST  (LAST),
    .BUSY  (BUSY),
    .DONE  (DONE)
`ifdef RESULT_READER_PARITY_EN
    ,
    .PAR   (PAR)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        abort;
    logic        ready;
    logic [35:0] r_in;
    logic        e_valid;
    logic [3:0]  e_dout;
    logic [1:0]  e_row;
    logic [1:0]  e_col;
    logic        e_last;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  logic [35:0] rin_a;
  logic [35:0] rin_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Non-streaming cycle: outputs expected before this edge, inputs applied at it.
  task automatic add_ctl(input logic start, input logic abort, input logic [35:0] rin,
                         input logic e_done, input logic e_busy);
    vec_t v;
    v.start = start; v.abort = abort; v.ready = 1'b0; v.r_in = rin;
    v.e_valid = 1'b0; v.e_dout = 4'd0; v.e_row = 2'd0; v.e_col = 2'd0;
    v.e_last = 1'b0; v.e_done = e_done; v.e_busy = e_busy;
    tbl.push_back(v);
  endtask

  // Cycle presenting word k (cell value k+1) of the snapshot.
  task automatic add_word(input int k, input logic start, input logic abort,
                          input logic ready, input logic [35:0] rin);
    vec_t v;
    v.start = start; v.abort = abort; v.ready = ready; v.r_in = rin;
    v.e_valid = 1'b1; v.e_dout = 4'(k + 1); v.e_row = 2'(k / 3); v.e_col = 2'(k % 3);
    v.e_last = (k == 8); v.e_done = 1'b0; v.e_busy = 1'b1;
    tbl.push_back(v);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, " ctrl"}, {28'd0, VALID, BUSY, DONE, LAST}, 32'd0);
    chk({name, " data"}, {24'd0, DOUT, ROW, COL}, 32'd0);
  endtask

  initial begin
    int k;
    int p;
    for (int i = 0; i < 9; i++) rin_a[i*4 +: 4] = 4'(i + 1);
    rin_f = '1;

    RST = 1'b1; START = 1'b0; ABORT = 1'b0; READY = 1'b0; R_IN = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Full stream with READY=1; START and ABORT in FIN are ignored.
    add_ctl(1'b1, 1'b0, rin_a, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) add_word(j, 1'b0, 1'b0, 1'b1, rin_a);
    add_ctl(1'b1, 1'b1, rin_a, 1'b1, 1'b1);
    add_ctl(1'b0, 1'b0, rin_a, 1'b0, 1'b0);
    add_ctl(1'b0, 1'b0, rin_a, 1'b0, 1'b0);

    // READY pattern 1,0,0 repeating; R_IN forced to F after capture; START while busy.
    add_ctl(1'b1, 1'b0, rin_a, 1'b0, 1'b0);
    k = 0; p = 0;
    while (k < 9) begin
      add_word(k, (p == 4), 1'b0, (p % 3 == 0), rin_f);
      if (p % 3 == 0) k++;
      p++;
    end
    add_ctl(1'b0, 1'b0, rin_f, 1'b1, 1'b1);
    add_ctl(1'b0, 1'b1, rin_f, 1'b0, 1'b0);

    // ABORT after third handshake, then ABORT+START in IDLE, then ABORT on the last handshake.
    add_ctl(1'b1, 1'b0, rin_a, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) add_word(j, 1'b0, 1'b0, 1'b1, rin_a);
    add_word(3, 1'b0, 1'b1, 1'b1, rin_a);
    add_ctl(1'b1, 1'b1, rin_a, 1'b0, 1'b0);
    add_word(0, 1'b0, 1'b0, 1'b0, rin_a);
    for (int j = 0; j < 8; j++) add_word(j, 1'b0, 1'b0, 1'b1, rin_a);
    add_word(8, 1'b0, 1'b1, 1'b1, rin_a);
    add_ctl(1'b0, 1'b0, rin_a, 1'b0, 1'b0);
    add_ctl(1'b0, 1'b0, rin_a, 1'b0, 1'b0);

    @(posedge CLK); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      START = tbl[i].start; ABORT = tbl[i].abort; READY = tbl[i].ready; R_IN = tbl[i].r_in;
      @(negedge CLK);
      chk($sformatf("vec%0d ctrl", i), {28'd0, VALID, BUSY, DONE, LAST},
          {28'd0, tbl[i].e_valid, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_last});
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d data", i), {24'd0, DOUT, ROW, COL},
            {24'd0, tbl[i].e_dout, tbl[i].e_row, tbl[i].e_col});
`ifdef RESULT_READER_PARITY_EN
        chk($sformatf("vec%0d par", i), {31'd0, PAR}, {31'd0, ^tbl[i].e_dout});
`endif
      end
      @(posedge CLK); #1;
    end
    START = 1'b0; ABORT = 1'b0; READY = 1'b0;

    // Stall on DOUT=5, retrigger START with new R_IN, then reset mid-cycle.
    START = 1'b1; R_IN = rin_a;
    @(posedge CLK); #1;
    START = 1'b0; R_IN = rin_f; READY = 1'b1;
    repeat (4) begin @(posedge CLK); #1; end
    READY = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    chk("stall dout5", {24'd0, DOUT, ROW, COL}, {24'd0, 4'd5, 2'd1, 2'd1});
    chk("stall valid", {31'd0, VALID}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check_all_zero("async rst");
    @(posedge CLK); #1;
    RST = 1'b0;
    R_IN = rin_a;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("post rst idle%0d", i), {28'd0, VALID, BUSY, DONE, LAST}, 32'd0);
    end
    @(posedge CLK); #1;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    chk("restart ctrl", {28'd0, VALID, BUSY, DONE, LAST}, {28'd0, 4'b1100});
    chk("restart data", {24'd0, DOUT, ROW, COL}, {24'd0, 4'd1, 2'd0, 2'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
